riscv_core_ext_irq_ctrl: RTL and testbench

- Machine-mode external interrupt controller; the requesting end of the CSR unit's external-interrupt handshake.
- Collects NUM_SRC edge-triggered peripheral interrupt lines into a pending set, masks them, and selects a winner by fixed priority.
- Drives the single machine-external request line into the CSR unit and consumes its one-cycle acknowledge pulse as the claim.
- The trap handler reads the claimed ID and writes it back to signal completion, through a small register port.

---
 rtl/riscv_core_ext_irq_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_riscv_core_ext_irq_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_core_ext_irq_ctrl.sv
// riscv_core_ext_irq_ctrl
//   Machine-mode external interrupt controller. Latches rising edges of
//   NUM_SRC peripheral lines into a pending set, masks them with ENABLE and
//   raises a single machine-external request toward the CSR unit. The CSR
//   unit's one-cycle ack claims the lowest-index eligible source; the trap
//   handler reads its ID from CLAIM and writes it to COMPLETE when done.
//
// Optional feature (compile-time macro): RISCV_CORE_IRQ_ACK_TIMEOUT_EN
//   Defined   : a request left unacknowledged for ACK_TIMEOUT cycles is
//               withdrawn (pending kept) and STATUS bit1 (sticky, W1C) sets.
//   Undefined : the request waits for ack indefinitely; STATUS bit1 reads 0.
//
// Ports
//   i_riscv_core_clk        clock, rising edge
//   i_riscv_core_rst        asynchronous active-high reset
//   i_riscv_core_irq_src    peripheral interrupt lines (edge-sensitive)
//   o_riscv_core_mexternal  request to CSR unit (registered)
//   i_riscv_core_ack        one-cycle acknowledge / claim pulse
//   i_riscv_core_reg_wen    register write strobe
//   i_riscv_core_reg_addr   register offset (0 EN,1 PEND,2 CLAIM,3 COMPLETE,4 STATUS)
//   i_riscv_core_reg_wdata  register write data
//   o_riscv_core_reg_rdata  register read data, 1-cycle latency
//   o_riscv_core_claim_id   currently claimed ID (source index + 1), 0 = none
module riscv_core_ext_irq_ctrl #(
  parameter int unsigned NUM_SRC     = 8,
  parameter int unsigned ID_W        = 6,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic               i_riscv_core_clk,
  input  logic               i_riscv_core_rst,
  input  logic [NUM_SRC-1:0] i_riscv_core_irq_src,
  output logic               o_riscv_core_mexternal,
  input  logic               i_riscv_core_ack,
  input  logic               i_riscv_core_reg_wen,
  input  logic [2:0]         i_riscv_core_reg_addr,
  input  logic [63:0]        i_riscv_core_reg_wdata,
  output logic [63:0]        o_riscv_core_reg_rdata,
  output logic [ID_W-1:0]    o_riscv_core_claim_id
);

  localparam int unsigned RD_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_CLAIMED = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] prev_src;
  logic               status_to;

  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c_mask;
  logic [NUM_SRC-1:0] claim_mask;
  logic [NUM_SRC-1:0] pending_nxt;
  logic [ID_W-1:0]    win_idx;
  logic               any_elig;
  logic               ack_claim;
  logic               wr_enable;
  logic               wr_pending;
  logic               wr_complete;
  logic               wr_status;
  logic               complete_hit;
  logic               timeout_hit;
  logic [RD_W-1:0]    rd_val;
  logic               unused_wdata;

  assign eligible    = pending & enable;
  assign any_elig    = |eligible;
  assign rise        = i_riscv_core_irq_src & ~prev_src;

  assign wr_enable   = i_riscv_core_reg_wen && (i_riscv_core_reg_addr == 3'd0);
  assign wr_pending  = i_riscv_core_reg_wen && (i_riscv_core_reg_addr == 3'd1);
  assign wr_complete = i_riscv_core_reg_wen && (i_riscv_core_reg_addr == 3'd3);
  assign wr_status   = i_riscv_core_reg_wen && (i_riscv_core_reg_addr == 3'd4);

  assign unused_wdata = ^i_riscv_core_reg_wdata;

  // Lowest set index wins: scan downward so the last hit is the lowest.
  always_comb begin
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_idx = ID_W'(i);
    end
  end

  assign ack_claim    = (state == ST_REQ) && i_riscv_core_ack && any_elig;
  assign claim_mask   = ack_claim ? (NUM_SRC'(1) << win_idx) : '0;
  assign w1c_mask     = wr_pending ? i_riscv_core_reg_wdata[NUM_SRC-1:0] : '0;
  assign complete_hit = wr_complete && (state == ST_CLAIMED) &&
                        (i_riscv_core_reg_wdata[ID_W-1:0] == o_riscv_core_claim_id);

  // Clears are applied first so a same-cycle new edge keeps its pending bit.
  assign pending_nxt  = (pending & ~(w1c_mask | claim_mask)) | rise;

`ifdef RISCV_CORE_IRQ_ACK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
  logic [CNT_W-1:0] ack_cnt;

  // Counts completed REQ cycles; held at zero outside REQ so entry starts fresh.
  always_ff @(posedge i_riscv_core_clk or posedge i_riscv_core_rst) begin
    if (i_riscv_core_rst) begin
      ack_cnt <= '0;
    end else if (state != ST_REQ || timeout_hit) begin
      ack_cnt <= '0;
    end else begin
      ack_cnt <= ack_cnt + CNT_W'(1);
    end
  end

  // Ack in the expiry cycle takes precedence.
  assign timeout_hit = (state == ST_REQ) && !i_riscv_core_ack && any_elig &&
                       (ack_cnt == CNT_W'(ACK_TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ACK_TIMEOUT[0];
  assign timeout_hit    = 1'b0;
`endif

  // Register read mux; sampled before this cycle's writes take effect.
  always_comb begin
    rd_val = '0;
    case (i_riscv_core_reg_addr)
      3'd0:    rd_val = RD_W'(enable);
      3'd1:    rd_val = RD_W'(pending);
      3'd2:    rd_val = RD_W'(o_riscv_core_claim_id);
      3'd4:    rd_val = RD_W'({status_to, (state != ST_IDLE)});
      default: rd_val = '0;
    endcase
  end

  // Handshake FSM, pending/enable/status registers and read data.
  always_ff @(posedge i_riscv_core_clk or posedge i_riscv_core_rst) begin
    if (i_riscv_core_rst) begin
      state                  <= ST_IDLE;
      pending                <= '0;
      enable                 <= '0;
      prev_src               <= '0;
      status_to              <= 1'b0;
      o_riscv_core_mexternal <= 1'b0;
      o_riscv_core_reg_rdata <= '0;
      o_riscv_core_claim_id  <= '0;
    end else begin
      prev_src               <= i_riscv_core_irq_src;
      pending                <= pending_nxt;
      o_riscv_core_reg_rdata <= rd_val;
      if (wr_enable) enable <= i_riscv_core_reg_wdata[NUM_SRC-1:0];
      if (timeout_hit) begin
        status_to <= 1'b1;
      end else if (wr_status && i_riscv_core_reg_wdata[1]) begin
        status_to <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (any_elig) begin
            state                  <= ST_REQ;
            o_riscv_core_mexternal <= 1'b1;
          end
        end
        ST_REQ: begin
          if (i_riscv_core_ack) begin
            o_riscv_core_mexternal <= 1'b0;
            if (any_elig) begin
              o_riscv_core_claim_id <= win_idx + ID_W'(1);
              state                 <= ST_CLAIMED;
            end else begin
              state <= ST_IDLE;
            end
          end else if (!any_elig || timeout_hit) begin
            o_riscv_core_mexternal <= 1'b0;
            state                  <= ST_IDLE;
          end
        end
        ST_CLAIMED: begin
          if (complete_hit) begin
            o_riscv_core_claim_id <= '0;
            state                 <= ST_IDLE;
          end
        end
        default: begin
          state                  <= ST_IDLE;
          o_riscv_core_mexternal <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_core_ext_irq_ctrl.sv
// Testbench for riscv_core_ext_irq_ctrl: one table row per clock cycle with
// hand-computed outputs, followed by reset-mid-request and ack-timeout
// sequences. Build with +define+RISCV_CORE_IRQ_ACK_TIMEOUT_EN to cover the
// timeout feature (the DUT is instantiated with ACK_TIMEOUT = 4).
module tb_riscv_core_ext_irq_ctrl;

  localparam int unsigned NUM_SRC = 8;
  localparam int unsigned ID_W    = 6;

  logic               clk;
  logic               rst;
  logic [NUM_SRC-1:0] irq_src;
  logic               mext;
  logic               ack;
  logic               wen;
  logic [2:0]         addr;
  logic [63:0]        wdata;
  logic [63:0]        rdata;
  logic [ID_W-1:0]    claim_id;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [7:0]  src;
    logic        ack;
    logic        wen;
    logic [2:0]  addr;
    logic [63:0] wdata;
    logic        exp_mext;
    logic [5:0]  exp_claim;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  riscv_core_ext_irq_ctrl #(
    .NUM_SRC    (NUM_SRC),
    .ID_W       (ID_W),
    .ACK_TIMEOUT(4)
  ) dut (
    .i_riscv_core_clk      (clk),
    .i_riscv_core_rst      (rst),
    .i_riscv_core_irq_src  (irq_src),
    .o_riscv_core_mexternal(mext),
    .i_riscv_core_ack      (ack),
    .i_riscv_core_reg_wen  (wen),
    .i_riscv_core_reg_addr (addr),
    .i_riscv_core_reg_wdata(wdata),
    .o_riscv_core_reg_rdata(rdata),
    .o_riscv_core_claim_id (claim_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [7:0] s, input logic a, input logic w, input logic [2:0] ad,
                     input logic [63:0] wd, input logic em, input logic [5:0] ec,
                     input logic [63:0] er);
    vec_t v;
    v.src = s; v.ack = a; v.wen = w; v.addr = ad; v.wdata = wd;
    v.exp_mext = em; v.exp_claim = ec; v.exp_rd = er;
    vecs.push_back(v);
  endtask

  // One clock: drive at negedge, return at the next negedge for sampling.
  task automatic cyc(input logic [7:0] s, input logic a, input logic w,
                     input logic [2:0] ad, input logic [63:0] wd);
    irq_src = s; ack = a; wen = w; addr = ad; wdata = wd;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int hi;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; irq_src = '0; ack = 1'b0; wen = 1'b0; addr = 3'd7; wdata = '0;

    //  src   ack wen addr wdata         mext claim rdata
    add(8'h00, 0, 1, 3'd0, 64'h05,        0, 6'd0, 64'h00); // ENABLE=0x05
    add(8'h01, 0, 0, 3'd1, 64'h00,        0, 6'd0, 64'h00); // src0 edge
    add(8'h00, 0, 0, 3'd1, 64'h00,        1, 6'd0, 64'h01); // request raised
    add(8'h00, 0, 0, 3'd4, 64'h00,        1, 6'd0, 64'h01); // busy
    add(8'h00, 1, 0, 3'd2, 64'h00,        0, 6'd1, 64'h00); // ack -> claim 1
    add(8'h00, 0, 0, 3'd2, 64'h00,        0, 6'd1, 64'h01);
    add(8'h00, 0, 0, 3'd1, 64'h00,        0, 6'd1, 64'h00); // pending cleared
    add(8'h00, 0, 1, 3'd3, 64'h01,        0, 6'd0, 64'h00); // COMPLETE 1
    add(8'h00, 0, 0, 3'd4, 64'h00,        0, 6'd0, 64'h00); // STATUS 0
    add(8'h00, 0, 1, 3'd0, 64'hFF,        0, 6'd0, 64'h05); // ENABLE=0xFF
    add(8'h24, 0, 0, 3'd7, 64'h00,        0, 6'd0, 64'h00); // src5+src2
    add(8'h00, 0, 0, 3'd1, 64'h00,        1, 6'd0, 64'h24);
    add(8'h00, 1, 0, 3'd2, 64'h00,        0, 6'd3, 64'h00); // lowest wins: ID 3
    add(8'h00, 0, 0, 3'd1, 64'h00,        0, 6'd3, 64'h20);
    add(8'h00, 0, 1, 3'd3, 64'h03,        0, 6'd0, 64'h00); // COMPLETE 3
    add(8'h00, 0, 0, 3'd4, 64'h00,        1, 6'd0, 64'h00); // re-raise
    add(8'h00, 1, 0, 3'd2, 64'h00,        0, 6'd6, 64'h00); // ID 6
    add(8'h00, 0, 1, 3'd3, 64'h06,        0, 6'd0, 64'h00);
    add(8'h00, 0, 1, 3'd0, 64'h00,        0, 6'd0, 64'hFF); // ENABLE=0
    add(8'h10, 0, 0, 3'd7, 64'h00,        0, 6'd0, 64'h00); // src4 edge
    add(8'h00, 0, 0, 3'd1, 64'h00,        0, 6'd0, 64'h10); // pending, no req
    add(8'h00, 0, 0, 3'd1, 64'h00,        0, 6'd0, 64'h10);
    add(8'h00, 0, 1, 3'd0, 64'h10,        0, 6'd0, 64'h00); // old enable used
    add(8'h00, 0, 0, 3'd0, 64'h00,        1, 6'd0, 64'h10); // request raised
    add(8'h00, 0, 1, 3'd1, 64'h10,        1, 6'd0, 64'h10); // W1C pending
    add(8'h00, 0, 0, 3'd4, 64'h00,        0, 6'd0, 64'h01); // withdrawn
    add(8'h00, 0, 0, 3'd4, 64'h00,        0, 6'd0, 64'h00); // IDLE
    add(8'h00, 0, 1, 3'd0, 64'h02,        0, 6'd0, 64'h10); // ENABLE=0x02
    add(8'h02, 0, 0, 3'd7, 64'h00,        0, 6'd0, 64'h00); // src1 edge
    add(8'h00, 0, 0, 3'd1, 64'h00,        1, 6'd0, 64'h02);
    add(8'h00, 1, 0, 3'd7, 64'h00,        0, 6'd2, 64'h00); // claim 2
    add(8'h00, 0, 1, 3'd3, 64'h05,        0, 6'd2, 64'h00); // wrong COMPLETE
    add(8'h00, 0, 0, 3'd4, 64'h00,        0, 6'd2, 64'h01); // still busy
    add(8'h00, 0, 1, 3'd3, 64'h02,        0, 6'd0, 64'h00); // COMPLETE 2
    add(8'h00, 0, 0, 3'd4, 64'h00,        0, 6'd0, 64'h00);
    add(8'h00, 1, 0, 3'd2, 64'h00,        0, 6'd0, 64'h00); // ack in IDLE ignored
    add(8'h02, 0, 1, 3'd1, 64'h02,        0, 6'd0, 64'h00); // edge + W1C: set wins
    add(8'h00, 0, 0, 3'd1, 64'h00,        1, 6'd0, 64'h02);
    add(8'h00, 1, 0, 3'd7, 64'h00,        0, 6'd2, 64'h00);
    add(8'h00, 0, 1, 3'd3, 64'h02,        0, 6'd0, 64'h00);
    add(8'h00, 0, 1, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 0, 6'd0, 64'h00); // unmapped
    add(8'h00, 0, 0, 3'd5, 64'h00,        0, 6'd0, 64'h00);
    add(8'h00, 0, 0, 3'd0, 64'h00,        0, 6'd0, 64'h02); // enable untouched

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mext",  64'(mext),     64'h0);
    check("rst_claim", 64'(claim_id), 64'h0);
    check("rst_rdata", rdata,         64'h0);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      cyc(vecs[i].src, vecs[i].ack, vecs[i].wen, vecs[i].addr, vecs[i].wdata);
      check($sformatf("v%0d_mext", i),  64'(mext),     64'(vecs[i].exp_mext));
      check($sformatf("v%0d_claim", i), 64'(claim_id), 64'(vecs[i].exp_claim));
      check($sformatf("v%0d_rdata", i), rdata,         vecs[i].exp_rd);
    end

    // Asynchronous reset while a request is outstanding
    cyc(8'h02, 0, 0, 3'd7, 64'h0);
    cyc(8'h00, 0, 0, 3'd0, 64'h0);
    check("prerst_mext",  64'(mext), 64'h1);
    check("prerst_rdata", rdata,     64'h2);
    rst = 1'b1;
    #1;
    check("arst_mext",  64'(mext),     64'h0);
    check("arst_claim", 64'(claim_id), 64'h0);
    check("arst_rdata", rdata,         64'h0);
    @(negedge clk);
    rst = 1'b0;
    cyc(8'h00, 0, 0, 3'd1, 64'h0);
    check("arst_pending", rdata, 64'h0);
    cyc(8'h00, 1, 0, 3'd7, 64'h0);
    check("arst_ack_mext",  64'(mext),     64'h0);
    check("arst_ack_claim", 64'(claim_id), 64'h0);

    // Unacknowledged request
    cyc(8'h00, 0, 1, 3'd0, 64'h01);
    cyc(8'h01, 0, 0, 3'd7, 64'h0);
    cyc(8'h00, 0, 0, 3'd7, 64'h0);
    check("to_rise", 64'(mext), 64'h1);
    hi = 0;
    while (mext && hi < 20) begin
      hi++;
      cyc(8'h00, 0, 0, 3'd7, 64'h0);
    end
`ifdef RISCV_CORE_IRQ_ACK_TIMEOUT_EN
    check("to_req_cycles", 64'(hi), 64'd4);
    cyc(8'h00, 0, 0, 3'd4, 64'h0);
    check("to_status", rdata,     64'h2);
    check("to_reraise", 64'(mext), 64'h1);
    cyc(8'h00, 0, 0, 3'd1, 64'h0);
    check("to_pending", rdata, 64'h1);
    cyc(8'h00, 0, 1, 3'd4, 64'h2);
    cyc(8'h00, 0, 0, 3'd4, 64'h0);
    check("to_status_w1c", rdata, 64'h1);
`else
    check("noto_req_cycles", 64'(hi), 64'd20);
    cyc(8'h00, 0, 0, 3'd4, 64'h0);
    check("noto_status", rdata,     64'h1);
    check("noto_mext",   64'(mext), 64'h1);
`endif
    cyc(8'h00, 1, 0, 3'd7, 64'h0);
    check("late_ack_claim", 64'(claim_id), 64'h1);
    cyc(8'h00, 0, 1, 3'd3, 64'h1);
    check("late_complete", 64'(claim_id), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
